mult_div_unit: RTL

- Iterative HI/LO multiply/divide unit directly downstream of the register file.
- Consumes its two read operands (rs → data1, rt → data2) and executes MULT, MULTU, DIV and DIVU.
- Holds results in architectural HI/LO registers, which are read by MFHI/MFLO and written by MTHI/MTLO.
- Multi-cycle; the control path stalls on busy.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_iter_step.sv | 44 ++++
 rtl/mult_div_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation encodings,
// FSM state encoding, default sizing and small op-decode helpers.
package mdu_pkg;

    // Default operand width; HI and LO are each this wide.
    localparam int MDU_WIDTH = 32;
    // Default iteration-counter width; 2**MDU_CNT_W must exceed MDU_WIDTH.
    localparam int MDU_CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // Bit 1 of the op code separates divides from multiplies.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Bit 0 clear marks the signed variants (MULT, DIV).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
//   Multiply: radix-2 shift-add. acc = {partial product, remaining multiplier};
//             add the multiplicand into the upper half when the multiplier LSB
//             is set, then shift the whole accumulator right by one.
//   Divide:   restoring shift-subtract. acc = {partial remainder, dividend/quotient};
//             shift left by one, trial-subtract the divisor from the upper half
//             and shift the resulting quotient bit in at the bottom.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Compute both candidate next accumulators and select by operation class.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        acc_o   = acc_i;
        add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        trial   = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff    = trial - {1'b0, opnd_i};

        if (is_div_i) begin
            if (!diff[WIDTH]) begin
                // Trial remainder covers the divisor: keep the difference, quotient bit 1.
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                // Borrow: restore the shifted remainder, quotient bit 0.
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {add_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Operations work on operand magnitudes; signs are recorded at launch and
// applied in the FIX state. Results land in HI/LO WIDTH+1 cycles after the
// accepting edge, together with a one-cycle done pulse.
// Optional build macro MDU_FAST_MULT_EN: multiplies are computed in a single
// cycle with a wide combinational multiplier and skip the RUN state; divides
// are unaffected. Without the macro only the iterative datapath exists.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mdu_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;
    logic                 is_div_q;
    logic                 neg_lo_q;      // negate product / quotient
    logic                 neg_hi_q;      // negate remainder
    logic                 div_zero_q;
    logic [WIDTH-1:0]     raw_a_q;       // untouched dividend for divide-by-zero
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 a_neg_d;
    logic                 b_neg_d;
    logic [WIDTH-1:0]     abs_a_d;
    logic [WIDTH-1:0]     abs_b_d;
    logic [2*WIDTH-1:0]   acc_step_d;
    logic [WIDTH-1:0]     hi_res_d;
    logic [WIDTH-1:0]     lo_res_d;
`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0]   fast_prod_d;
`endif

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

    // Launch-time operand conditioning: magnitudes for signed ops, raw values otherwise.
    always_comb begin
        a_neg_d = op_is_signed(op) & rs_data[WIDTH-1];
        b_neg_d = op_is_signed(op) & rt_data[WIDTH-1];
        abs_a_d = a_neg_d ? -rs_data : rs_data;
        abs_b_d = b_neg_d ? -rt_data : rt_data;
    end

`ifdef MDU_FAST_MULT_EN
    // Single-cycle magnitude product used only by the fast multiply path.
    always_comb begin
        fast_prod_d = {{WIDTH{1'b0}}, abs_a_d} * {{WIDTH{1'b0}}, abs_b_d};
    end
`endif

    mdu_iter_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_step_d)
    );

    // Sign correction and divide-by-zero override of the finished accumulator.
    always_comb begin
        hi_res_d = acc_q[2*WIDTH-1:WIDTH];
        lo_res_d = acc_q[WIDTH-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                hi_res_d = raw_a_q;
                lo_res_d = '1;
            end else begin
                hi_res_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                lo_res_d = neg_lo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
            end
        end else if (neg_lo_q) begin
            {hi_res_d, lo_res_d} = -acc_q;
        end
    end

    // Control FSM with counter, datapath registers and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: datapath registers are cleared as well as control, so an aborted operation leaves nothing behind.
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            raw_a_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q   <= op_is_div(op);
                        neg_lo_q   <= a_neg_d ^ b_neg_d;
                        neg_hi_q   <= a_neg_d;
                        div_zero_q <= op_is_div(op) && (rt_data == '0);
                        raw_a_q    <= rs_data;
                        opnd_q     <= abs_b_d;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
`ifdef MDU_FAST_MULT_EN
                        if (!op_is_div(op)) begin
                            acc_q   <= fast_prod_d;
                            state_q <= FIX;
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, abs_a_d};
                            state_q <= RUN;
                        end
`else
                        acc_q   <= {{WIDTH{1'b0}}, abs_a_d};
                        state_q <= RUN;
`endif
                    end else begin
                        if (mthi) begin
                            hi_q <= rs_data;
                        end
                        if (mtlo) begin
                            lo_q <= rs_data;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_step_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= hi_res_d;
                    lo_q    <= lo_res_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
